// File: rtl/gpu_pkg.sv
// Shared GPU definitions: return-path tags, VRAM slot grant encoding and
// the saturating counter helper used by the arbiter.
package gpu_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    typedef enum logic [1:0] {
        GNT_IDLE     = 2'd0,
        GNT_DISP_RD  = 2'd1,
        GNT_WB_DRAIN = 2'd2,
        GNT_CPU_RD   = 2'd3
    } grant_t;

    localparam int CNT_W = 8;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/vram_write_buffer.sv
// One-entry posted-write buffer: captures a CPU write when empty and frees
// itself when the arbiter grants the drain slot.
module vram_write_buffer
    import gpu_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_drain,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata
);

    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Capture and drain are mutually exclusive: one needs empty, the other full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_capture && !r_full) begin
            r_full  <= 1'b1;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end else if (i_drain && r_full) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, CPU writes are posted,
// CPU reads use leftover slots, with a sticky CPU starvation flag.
module vram_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              starve_clr,
    output logic              cpu_starved,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic              w_wbFull;
    logic [ADDR_W-1:0] w_wbAddr;
    logic [DATA_W-1:0] w_wbData;
    logic              w_capture;
    logic              w_drain;
    logic              w_cpuRdBusy;
    logic              w_cpuRdOk;
    logic              w_cpuWait;
    logic [CNT_W-1:0]  w_cntNext;
    grant_t            w_grant;

    tag_t              r_tag1;
    tag_t              r_tag2;
    logic [CNT_W-1:0]  r_starveCnt;

    // The ack cycle still sees the old request held high; gating on cpu_ack
    // keeps that same request from being captured or granted a second time.
    assign w_cpuRdBusy = (r_tag1 == TAG_CPU) || (r_tag2 == TAG_CPU);
    assign w_capture   = cpu_req && cpu_we && !w_wbFull && !cpu_ack;
    assign w_cpuRdOk   = cpu_req && !cpu_we && !w_cpuRdBusy && !w_wbFull && !cpu_ack;
    assign w_drain     = (w_grant == GNT_WB_DRAIN);
    assign w_cpuWait   = cpu_req && !cpu_ack && !w_cpuRdBusy && !w_capture
                         && (w_grant != GNT_CPU_RD);
    assign w_cntNext   = satInc(r_starveCnt);

    always_comb begin
        w_grant = GNT_IDLE;
        if (disp_req) begin
            w_grant = GNT_DISP_RD;
        end else if (w_wbFull) begin
            w_grant = GNT_WB_DRAIN;
        end else if (w_cpuRdOk) begin
            w_grant = GNT_CPU_RD;
        end
    end

    vram_write_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_writeBuffer (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_capture),
        .i_drain   (w_drain),
        .i_addr    (cpu_addr),
        .i_wdata   (cpu_wdata),
        .o_full    (w_wbFull),
        .o_addr    (w_wbAddr),
        .o_wdata   (w_wbData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_addr  <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            r_tag1     <= TAG_NONE;
            r_tag2     <= TAG_NONE;
        end else begin
            r_tag2 <= r_tag1;
            case (w_grant)
                GNT_DISP_RD: begin
                    vram_addr <= disp_addr;
                    vram_we   <= 1'b0;
                    r_tag1    <= TAG_DISP;
                end
                GNT_WB_DRAIN: begin
                    vram_addr  <= w_wbAddr;
                    vram_we    <= 1'b1;
                    vram_wdata <= w_wbData;
                    r_tag1     <= TAG_NONE;
                end
                GNT_CPU_RD: begin
                    vram_addr <= cpu_addr;
                    vram_we   <= 1'b0;
                    r_tag1    <= TAG_CPU;
                end
                default: begin
                    vram_we <= 1'b0;
                    r_tag1  <= TAG_NONE;
                end
            endcase
        end
    end

    // Return path: the second tag stage lines up with vram_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            disp_valid <= (r_tag2 == TAG_DISP);
            cpu_ack    <= w_capture || (r_tag2 == TAG_CPU);
            if (r_tag2 == TAG_DISP) begin
                disp_data <= vram_rdata;
            end
            if (r_tag2 == TAG_CPU) begin
                cpu_rdata <= vram_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starveCnt <= '0;
            cpu_starved <= 1'b0;
        end else begin
            if (cpu_ack) begin
                r_starveCnt <= '0;
            end else if (w_cpuWait) begin
                r_starveCnt <= w_cntNext;
            end
            if (w_cpuWait && (w_cntNext >= LIMIT)) begin
                cpu_starved <= 1'b1;
            end else if (starve_clr) begin
                cpu_starved <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural VRAM and a scoreboard of
// expected display and CPU completions (data plus arrival cycle).
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dispReq = 1'b0;
    logic [14:0] dispAddr = '0;
    logic        dispValid;
    logic [7:0]  dispData;
    logic        cpuReq = 1'b0;
    logic        cpuWe = 1'b0;
    logic [14:0] cpuAddr = '0;
    logic [7:0]  cpuWdata = '0;
    logic        cpuAck;
    logic [7:0]  cpuRdata;
    logic        starveClr = 1'b0;
    logic        cpuStarved;
    logic [14:0] vramAddr;
    logic        vramWe;
    logic [7:0]  vramWdata;
    logic [7:0]  vramRdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ackSeen = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
        bit         isRead;
    } expItem_t;

    expItem_t dispQ[$];
    expItem_t cpuQ[$];

    vram_arbiter #(
        .ADDR_W       (15),
        .DATA_W       (8),
        .STARVE_LIMIT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_req    (dispReq),
        .disp_addr   (dispAddr),
        .disp_valid  (dispValid),
        .disp_data   (dispData),
        .cpu_req     (cpuReq),
        .cpu_we      (cpuWe),
        .cpu_addr    (cpuAddr),
        .cpu_wdata   (cpuWdata),
        .cpu_ack     (cpuAck),
        .cpu_rdata   (cpuRdata),
        .starve_clr  (starveClr),
        .cpu_starved (cpuStarved),
        .vram_addr   (vramAddr),
        .vram_we     (vramWe),
        .vram_wdata  (vramWdata),
        .vram_rdata  (vramRdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read VRAM; unwritten words hold a fixed address pattern
    // (address[7:0] throughout the low 256 words).
    bit [7:0] ramMem     [0:32767];
    bit       ramWritten [0:32767];

    function automatic logic [7:0] ramRead(input logic [14:0] a);
        return ramWritten[a] ? ramMem[a] : (a[7:0] ^ {1'b0, a[14:8]});
    endfunction

    always @(posedge clk) begin
        vramRdata <= ramRead(vramAddr);
        if (vramWe) begin
            ramMem[vramAddr]     <= vramWdata;
            ramWritten[vramAddr] <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushCpu(input bit isRead, input logic [7:0] data, input int due);
        expItem_t e;
        e.data   = data;
        e.due    = due;
        e.isRead = isRead;
        cpuQ.push_back(e);
    endtask

    // Advances one cycle; the CPU side drops its request once it sees the ack.
    task automatic applyStimulus(input bit dReq, input logic [14:0] dAddr);
        expItem_t e;
        @(posedge clk);
        #1;
        if (cpuAck) cpuReq = 1'b0;
        starveClr = 1'b0;
        dispReq   = dReq;
        dispAddr  = dAddr;
        if (dReq) begin
            e.data   = dAddr[7:0];
            e.due    = cyc + 3;
            e.isRead = 1'b1;
            dispQ.push_back(e);
        end
    endtask

    task automatic issueCpu(input bit we, input logic [14:0] addr, input logic [7:0] wdata);
        cpuReq   = 1'b1;
        cpuWe    = we;
        cpuAddr  = addr;
        cpuWdata = wdata;
    endtask

    task automatic waitCpuDone(input string tag, input int maxCycles);
        int n = 0;
        while (cpuReq && n < maxCycles) begin
            applyStimulus(1'b0, '0);
            n++;
        end
        checkOutput({tag, "_timeout"}, {31'b0, cpuReq}, 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_vram_addr"},   {17'b0, vramAddr},  32'd0);
        checkOutput({tag, "_vram_we"},     {31'b0, vramWe},    32'd0);
        checkOutput({tag, "_vram_wdata"},  {24'b0, vramWdata}, 32'd0);
        checkOutput({tag, "_disp_valid"},  {31'b0, dispValid}, 32'd0);
        checkOutput({tag, "_disp_data"},   {24'b0, dispData},  32'd0);
        checkOutput({tag, "_cpu_ack"},     {31'b0, cpuAck},    32'd0);
        checkOutput({tag, "_cpu_rdata"},   {24'b0, cpuRdata},  32'd0);
        checkOutput({tag, "_cpu_starved"}, {31'b0, cpuStarved}, 32'd0);
    endtask

    // Scoreboard side: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        expItem_t e;
        if (!rst) begin
            if (dispValid) begin
                if (dispQ.size() == 0) begin
                    checkOutput("disp_unexpected", {31'b0, dispValid}, 32'd0);
                end else begin
                    e = dispQ.pop_front();
                    checkOutput("disp_data", {24'b0, dispData}, {24'b0, e.data});
                    checkOutput("disp_cycle", cyc, e.due);
                end
            end
            if (cpuAck) begin
                ackSeen++;
                if (cpuQ.size() == 0) begin
                    checkOutput("cpu_ack_unexpected", {31'b0, cpuAck}, 32'd0);
                end else begin
                    e = cpuQ.pop_front();
                    checkOutput("cpu_ack_cycle", cyc, e.due);
                    if (e.isRead) checkOutput("cpu_rdata", {24'b0, cpuRdata}, {24'b0, e.data});
                end
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ackSnap;

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("rst_init");
        rst = 1'b0;

        // Display streaming 0x0000..0x003F, one read per cycle.
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 15'(i));
        repeat (4) applyStimulus(1'b0, '0);

        // Uncontended write then read-back.
        applyStimulus(1'b0, '0);
        issueCpu(1'b1, 15'h1234, 8'hA5);
        pushCpu(1'b0, 8'h00, cyc + 1);
        waitCpuDone("wr_1234", 10);
        applyStimulus(1'b0, '0);
        issueCpu(1'b0, 15'h1234, 8'h00);
        pushCpu(1'b1, 8'hA5, cyc + 3);
        waitCpuDone("rd_1234", 10);

        // Alternate-cycle display traffic; the CPU read waits for the gap.
        applyStimulus(1'b1, 15'h0020);
        issueCpu(1'b0, 15'h0100, 8'h00);
        pushCpu(1'b1, 8'h01, cyc + 4);
        for (int k = 1; k < 10; k++) applyStimulus((k % 2) == 0, 15'(32 + k));
        checkOutput("contention_done", {31'b0, cpuReq}, 32'd0);

        // Read-after-write under 10 cycles of continuous display reads.
        applyStimulus(1'b1, 15'h0000);
        issueCpu(1'b1, 15'h0200, 8'h5A);
        pushCpu(1'b0, 8'h00, cyc + 1);
        applyStimulus(1'b1, 15'h0001);
        issueCpu(1'b0, 15'h0200, 8'h00);
        pushCpu(1'b1, 8'h5A, cyc + 13);
        for (int i = 2; i < 10; i++) applyStimulus(1'b1, 15'(i));
        waitCpuDone("raw_0200", 20);
        checkOutput("raw_not_starved", {31'b0, cpuStarved}, 32'd0);

        // Starvation with STARVE_LIMIT = 16 and the display hogging every slot.
        applyStimulus(1'b1, 15'h0000);
        issueCpu(1'b0, 15'h0100, 8'h00);
        pushCpu(1'b1, 8'h01, cyc + 20);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 15'(i % 64));
            if (i == 15) checkOutput("starve_before_limit", {31'b0, cpuStarved}, 32'd0);
            if (i == 16) checkOutput("starve_at_limit", {31'b0, cpuStarved}, 32'd1);
        end
        waitCpuDone("starve_rd", 10);
        checkOutput("starve_sticky", {31'b0, cpuStarved}, 32'd1);
        applyStimulus(1'b0, '0);
        starveClr = 1'b1;
        applyStimulus(1'b0, '0);
        checkOutput("starve_cleared", {31'b0, cpuStarved}, 32'd0);

        // Reset during an in-flight CPU read: no ack may follow.
        repeat (4) applyStimulus(1'b0, '0);
        applyStimulus(1'b0, '0);
        issueCpu(1'b0, 15'h0100, 8'h00);
        applyStimulus(1'b0, '0);
        ackSnap = ackSeen;
        rst = 1'b1;
        cpuReq = 1'b0;
        #1;
        checkResetOutputs("rst_mid_read");
        applyStimulus(1'b0, '0);
        applyStimulus(1'b0, '0);
        rst = 1'b0;
        repeat (6) applyStimulus(1'b0, '0);
        checkOutput("rst_read_no_ack", ackSeen, ackSnap);

        // Reset while a posted write is stuck behind display reads.
        applyStimulus(1'b1, 15'h0000);
        issueCpu(1'b1, 15'h0300, 8'h77);
        pushCpu(1'b0, 8'h00, cyc + 1);
        applyStimulus(1'b1, 15'h0001);
        applyStimulus(1'b1, 15'h0002);
        rst = 1'b1;
        dispReq = 1'b0;
        cpuReq = 1'b0;
        dispQ.delete();
        #1;
        checkResetOutputs("rst_mid_write");
        applyStimulus(1'b0, '0);
        rst = 1'b0;
        ackSnap = ackSeen;
        repeat (6) applyStimulus(1'b0, '0);
        checkOutput("rst_write_discarded", {24'b0, ramRead(15'h0300)}, 32'h03);
        checkOutput("rst_write_no_ack", ackSeen, ackSnap);

        // Normal operation resumes after reset.
        applyStimulus(1'b0, '0);
        issueCpu(1'b1, 15'h0010, 8'h3C);
        pushCpu(1'b0, 8'h00, cyc + 1);
        waitCpuDone("wr_0010", 10);
        applyStimulus(1'b0, '0);
        issueCpu(1'b0, 15'h0010, 8'h00);
        pushCpu(1'b1, 8'h3C, cyc + 3);
        waitCpuDone("rd_0010", 10);

        for (int n = 0; n < 20 && (dispQ.size() != 0 || cpuQ.size() != 0); n++) begin
            applyStimulus(1'b0, '0);
        end
        checkOutput("disp_queue_empty", dispQ.size(), 32'd0);
        checkOutput("cpu_queue_empty", cpuQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM arbiter for the GPU. It shares one synchronous-read video RAM between two requesters:
- the display fetch path, which reads pixel/tile data in step with the sync generator and must never be stalled;
- the CPU bus path, which carries register-mapped reads and writes from the host.

Display requests always win. CPU writes are posted through a one-entry buffer, and CPU reads complete in leftover slots. A sticky flag reports when the CPU has been starved beyond a programmable limit.

## Interface
Parameters:
- ADDR_W, 15, VRAM word-address width
- DATA_W, 8, VRAM word width
- STARVE_LIMIT, 64, CPU wait cycles (pending, ungranted) before `cpu_starved` sets; legal range 1..255

Ports:
- clk  in  1  system clock (100 MHz domain); the only clock
- rst  in  1  reset, asynchronous, active-high
- disp_req  in  1  display fetch request, valid for the current cycle only
- disp_addr  in  ADDR_W  display fetch address
- disp_valid  out  1  display read data valid (pulse)
- disp_data  out  DATA_W  display read data
- cpu_req  in  1  CPU access request; held high until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read; stable while `cpu_req` is high
- cpu_addr  in  ADDR_W  CPU address; stable while `cpu_req` is high
- cpu_wdata  in  DATA_W  CPU write data; stable while `cpu_req` is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  CPU read data; valid while `cpu_ack` is high for a read, held afterwards
- starve_clr  in  1  clears `cpu_starved`
- cpu_starved  out  1  sticky starvation flag
- vram_addr  out  ADDR_W  registered RAM address
- vram_we  out  1  registered RAM write enable
- vram_wdata  out  DATA_W  registered RAM write data
- vram_rdata  in  DATA_W  RAM read data, one cycle after the address is presented

## Operation
One VRAM slot is granted per `clk` cycle, decided combinationally from current inputs. Priority order:
1. `disp_req` (display read).
2. Write-buffer drain, if the buffer is full.
3. CPU read, if `cpu_req` is high, `cpu_we` is 0, no CPU read is in flight, and the write buffer is empty.
4. Idle: `vram_we` = 0 and `vram_addr` holds its previous value.

Write buffer (one entry):
- A CPU write with the buffer empty is captured at the clock edge.
- `cpu_ack` pulses in the cycle after capture, whether or not the buffer drains in that same cycle.
- A CPU write with the buffer full waits. Capture occurs in the cycle after the drain grant.

Read ordering:
- CPU reads are blocked while the buffer is full. This guarantees read-after-write ordering without forwarding.

Return-path tag pipeline (2 stages):
- Each granted read carries a tag (DISP or CPU) down the pipeline, alongside `vram_we` = 0.
- On the pipeline output, a DISP tag raises `disp_valid`, and a CPU tag raises `cpu_ack` and loads `cpu_rdata`. Both take their data from `vram_rdata`.
- At most one CPU read is in flight, so `cpu_req` must drop before a second read can be granted.

Starvation counter (8-bit, saturating):
- Increments each cycle that `cpu_req` is high and the CPU operation is neither granted nor captured.
- Resets to 0 on each `cpu_ack`.
- When the count reaches STARVE_LIMIT, `cpu_starved` sets and stays set until `starve_clr`. If `starve_clr` and the set condition occur in the same cycle, set wins.

Reset behaviour:
- Asserting `rst` mid-operation discards any buffered write and any in-flight reads.
- No ack is issued for discarded operations.

## Timing
- Reset values: `vram_addr` = 0, `vram_we` = 0, `vram_wdata` = 0, `disp_valid` = 0, `disp_data` = 0, `cpu_ack` = 0, `cpu_rdata` = 0, `cpu_starved` = 0, write buffer empty, pipeline tags empty, counter = 0.
- Display read latency, with grant in cycle N:
  - `vram_addr` is registered at the end of N.
  - RAM data returns in N+2.
  - `disp_valid` and `disp_data` are registered in N+3. Fixed latency is 3 cycles.
- CPU read with no contention: `cpu_req` rises in N, the grant is in N, and `cpu_ack` with `cpu_rdata` arrives in N+3.
- CPU write with no contention: captured at the end of N, `cpu_ack` in N+1, drain grant in N+1, and the RAM write occurs at the end of N+2.
- With `disp_req` high in every cycle, the CPU is never granted. `cpu_starved` rises exactly STARVE_LIMIT cycles after `cpu_req` rises.
- Back-to-back `disp_req` is supported at one read per cycle with no bubbles.

## Structure
- Shared package `gpu_pkg`: the tag encoding (NONE/DISP/CPU) and the grant encoding (IDLE/DISP_RD/WB_DRAIN/CPU_RD).
- Sub-module `vram_write_buffer`: the one-entry posted-write register with full flag, capture, and drain handshake.
- The grant logic, tag pipeline and starvation counter remain in `vram_arbiter`.

## Test plan
- Reset: assert `rst` mid-write and mid-read. All outputs read 0, no `cpu_ack` follows, and the next CPU write to address 0x0010 succeeds.
- Display streaming: `disp_req` every cycle for addresses 0x0000..0x003F with RAM preloaded with data = address[7:0]. Expect 64 consecutive `disp_valid` pulses, each 3 cycles after its request, with matching data.
- CPU write then read:
  - Write 0xA5 to 0x1234 → `cpu_ack` after 1 cycle.
  - Then read 0x1234 → `cpu_ack` after 3 cycles with `cpu_rdata` = 0xA5.
- Contention: `disp_req` on alternate cycles plus a pending CPU read of 0x0100. The CPU read is granted only in an idle cycle, and every display read keeps its 3-cycle latency.
- Read-after-write ordering: a write of 0x5A to 0x0200, immediately followed by a read of 0x0200 under continuous `disp_req` for 10 cycles. The read returns 0x5A and is never granted before the drain.
- Starvation, with STARVE_LIMIT = 16 and `disp_req` held high:
  - A CPU read pending → `cpu_starved` rises on the 16th wait cycle.
  - Drop `disp_req` → the read completes and the flag stays high.
  - `starve_clr` → the flag drops.
